// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece and rotation codes, rotation-FSM states, kick count.
// Defining TETRIS_ROTATE_180_EN widens the rotate direction to 2 bits and enables the 180 path.
package tetris_pkg;

  typedef enum logic [3:0] {
    PIECE_NONE = 4'd0,
    PIECE_L    = 4'd1,
    PIECE_J    = 4'd2,
    PIECE_I    = 4'd3,
    PIECE_O    = 4'd4,
    PIECE_Z    = 4'd5,
    PIECE_S    = 4'd6,
    PIECE_T    = 4'd7
  } piece_e;

  typedef enum logic [1:0] {
    ROT_0 = 2'd0,
    ROT_R = 2'd1,
    ROT_2 = 2'd2,
    ROT_L = 2'd3
  } rot_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } rot_state_e;

  localparam int KICKS_DEF = 5;

`ifdef TETRIS_ROTATE_180_EN
  localparam int DIR_W = 2;
`else
  localparam int DIR_W = 1;
`endif

  // Target rotation; the unused direction code 3 behaves as clockwise.
  function automatic logic [1:0] calc_to_rot(input logic [1:0] rot, input logic [DIR_W-1:0] dir);
`ifdef TETRIS_ROTATE_180_EN
    case (dir)
      2'd1:    return rot - 2'd1;
      2'd2:    return rot + 2'd2;
      default: return rot + 2'd1;
    endcase
`else
    return dir[0] ? rot - 2'd1 : rot + 2'd1;
`endif
  endfunction

endpackage

// File: rtl/tetromino_rotate_datum.sv
// SRS offset table: per-piece, per-rotation origin offset for kick index 0..4.
// Kicks are formed by the caller as offset(from) - offset(to); unused indices read as zero.
module tetromino_rotate_datum
  import tetris_pkg::*;
(
  input  logic [3:0]        i_piece,
  input  logic [1:0]        i_rot,
  input  logic [2:0]        i_idx,
  output logic signed [2:0] o_dx,
  output logic signed [2:0] o_dy
);

  always_comb begin
    o_dx = '0;
    o_dy = '0;
    if (i_piece == PIECE_O) begin
      // O only ever uses index 0; its offsets keep the 2x2 block in place.
      case (i_rot)
        ROT_R:   o_dy = -3'sd1;
        ROT_2:   begin o_dx = -3'sd1; o_dy = -3'sd1; end
        ROT_L:   o_dx = -3'sd1;
        default: ;
      endcase
    end else if (i_piece == PIECE_I) begin
      case (i_rot)
        ROT_0: case (i_idx)
          3'd1, 3'd3: o_dx = -3'sd1;
          3'd2, 3'd4: o_dx = 3'sd2;
          default: ;
        endcase
        ROT_R: case (i_idx)
          3'd0:    o_dx = -3'sd1;
          3'd3:    o_dy = 3'sd1;
          3'd4:    o_dy = -3'sd2;
          default: ;
        endcase
        ROT_2: case (i_idx)
          3'd0:    begin o_dx = -3'sd1; o_dy = 3'sd1; end
          3'd1:    begin o_dx = 3'sd1;  o_dy = 3'sd1; end
          3'd2:    begin o_dx = -3'sd2; o_dy = 3'sd1; end
          3'd3:    o_dx = 3'sd1;
          3'd4:    o_dx = -3'sd2;
          default: ;
        endcase
        default: case (i_idx)
          3'd0, 3'd1, 3'd2: o_dy = 3'sd1;
          3'd3:    o_dy = -3'sd1;
          3'd4:    o_dy = 3'sd2;
          default: ;
        endcase
      endcase
    end else if (i_piece inside {PIECE_L, PIECE_J, PIECE_Z, PIECE_S, PIECE_T}) begin
      // J/L/S/T/Z: rotations 0 and 2 are all-zero, L mirrors R in x.
      if (i_rot == ROT_R || i_rot == ROT_L) begin
        case (i_idx)
          3'd1:    o_dx = 3'sd1;
          3'd2:    begin o_dx = 3'sd1; o_dy = -3'sd1; end
          3'd3:    o_dy = 3'sd2;
          3'd4:    begin o_dx = 3'sd1; o_dy = 3'sd2; end
          default: ;
        endcase
        if (i_rot == ROT_L) o_dx = -o_dx;
      end
    end
  end

endmodule

// File: rtl/tetromino_rotate_ctrl.sv
// Sequential SRS rotation controller: walks kick candidates and commits the first non-colliding one.
// Defining TETRIS_ROTATE_180_EN adds a single-candidate 180-degree rotation (req_dir == 2).
module tetromino_rotate_ctrl
  import tetris_pkg::*;
#(
  parameter int X_W   = 5,
  parameter int Y_W   = 7,
  parameter int KICKS = KICKS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIR_W-1:0] req_dir,
  input  logic [3:0]       piece,
  input  logic [1:0]       cur_rot,
  input  logic [X_W-1:0]   cur_x,
  input  logic [Y_W-1:0]   cur_y,
  output logic             chk_valid,
  input  logic             chk_ready,
  output logic [3:0]       chk_piece,
  output logic [1:0]       chk_rot,
  output logic [X_W-1:0]   chk_x,
  output logic [Y_W-1:0]   chk_y,
  input  logic             chk_resp_valid,
  input  logic             chk_collide,
  output logic             done,
  output logic             done_ok,
  output logic [1:0]       new_rot,
  output logic [X_W-1:0]   new_x,
  output logic [Y_W-1:0]   new_y,
  output logic [2:0]       kick_idx
);

  rot_state_e       r_state, w_state_next;
  logic [3:0]       r_piece, r_chk_piece;
  logic [1:0]       r_cur_rot, r_chk_rot, r_new_rot;
  logic [X_W-1:0]   r_cur_x, r_chk_x, r_new_x;
  logic [Y_W-1:0]   r_cur_y, r_chk_y, r_new_y;
  logic [DIR_W-1:0] r_dir;
  logic [2:0]       r_idx, r_kick_idx, w_last_idx;
  logic             r_done_ok;

  logic [1:0]        w_to_rot;
  logic signed [2:0] w_from_dx, w_from_dy, w_to_dx, w_to_dy;
  logic [3:0]        w_dx, w_dy;
  logic [X_W-1:0]    w_cand_x;
  logic [Y_W-1:0]    w_cand_y;
  logic              w_resp, w_last;

  assign w_to_rot = calc_to_rot(r_cur_rot, r_dir);

  tetromino_rotate_datum u_from (
    .i_piece(r_piece), .i_rot(r_cur_rot), .i_idx(r_idx), .o_dx(w_from_dx), .o_dy(w_from_dy)
  );
  tetromino_rotate_datum u_to (
    .i_piece(r_piece), .i_rot(w_to_rot), .i_idx(r_idx), .o_dx(w_to_dx), .o_dy(w_to_dy)
  );

  // Kick components fit in 4 bits (-4..4); sign-extend and let the origin add wrap.
  assign w_dx     = {w_from_dx[2], w_from_dx} - {w_to_dx[2], w_to_dx};
  assign w_dy     = {w_from_dy[2], w_from_dy} - {w_to_dy[2], w_to_dy};
  assign w_cand_x = r_cur_x + {{(X_W-4){w_dx[3]}}, w_dx};
  assign w_cand_y = r_cur_y + {{(Y_W-4){w_dy[3]}}, w_dy};

  // O pieces and 180 turns have exactly one candidate.
  assign w_last_idx = (r_piece == PIECE_O || w_to_rot == r_cur_rot + 2'd2) ? 3'd0 : 3'(KICKS - 1);
  assign w_last     = (r_idx == w_last_idx);
  assign w_resp     = (r_state == ST_WAIT) && chk_resp_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_state_next = ST_CALC;
      ST_CALC:  w_state_next = ST_ISSUE;
      ST_ISSUE: if (chk_ready) w_state_next = ST_WAIT;
      ST_WAIT:  if (chk_resp_valid) w_state_next = (!chk_collide || w_last) ? ST_DONE : ST_CALC;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    chk_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: chk_valid = 1'b1;
      ST_DONE:  done      = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_piece     <= '0;
      r_cur_rot   <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_dir       <= '0;
      r_idx       <= '0;
      r_chk_piece <= '0;
      r_chk_rot   <= '0;
      r_chk_x     <= '0;
      r_chk_y     <= '0;
      r_new_rot   <= '0;
      r_new_x     <= '0;
      r_new_y     <= '0;
      r_kick_idx  <= '0;
      r_done_ok   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_piece   <= piece;
        r_cur_rot <= cur_rot;
        r_cur_x   <= cur_x;
        r_cur_y   <= cur_y;
        r_dir     <= req_dir;
        r_idx     <= '0;
      end
      if (r_state == ST_CALC) begin
        r_chk_piece <= r_piece;
        r_chk_rot   <= w_to_rot;
        r_chk_x     <= w_cand_x;
        r_chk_y     <= w_cand_y;
      end
      if (w_resp) begin
        if (!chk_collide) begin
          r_new_rot  <= r_chk_rot;
          r_new_x    <= r_chk_x;
          r_new_y    <= r_chk_y;
          r_kick_idx <= r_idx;
          r_done_ok  <= 1'b1;
        end else if (w_last) begin
          r_new_rot  <= r_cur_rot;
          r_new_x    <= r_cur_x;
          r_new_y    <= r_cur_y;
          r_kick_idx <= r_idx;
          r_done_ok  <= 1'b0;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign chk_piece = r_chk_piece;
  assign chk_rot   = r_chk_rot;
  assign chk_x     = r_chk_x;
  assign chk_y     = r_chk_y;
  assign new_rot   = r_new_rot;
  assign new_x     = r_new_x;
  assign new_y     = r_new_y;
  assign kick_idx  = r_kick_idx;
  assign done_ok   = r_done_ok;

endmodule

// File: tb/tb_tetromino_rotate_ctrl.sv
// Directed bench for tetromino_rotate_ctrl: scripted collision checker, hand-computed SRS results.
module tb_tetromino_rotate_ctrl;
  import tetris_pkg::*;

  localparam int X_W = 5;
  localparam int Y_W = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [DIR_W-1:0] req_dir = '0;
  logic [3:0]       piece = '0;
  logic [1:0]       cur_rot = '0;
  logic [X_W-1:0]   cur_x = '0;
  logic [Y_W-1:0]   cur_y = '0;
  logic             chk_valid;
  logic             chk_ready = 1'b0;
  logic [3:0]       chk_piece;
  logic [1:0]       chk_rot;
  logic [X_W-1:0]   chk_x;
  logic [Y_W-1:0]   chk_y;
  logic             chk_resp_valid = 1'b0;
  logic             chk_collide = 1'b0;
  logic             done;
  logic             done_ok;
  logic [1:0]       new_rot;
  logic [X_W-1:0]   new_x;
  logic [Y_W-1:0]   new_y;
  logic [2:0]       kick_idx;

  int checks = 0;
  int errors = 0;

  logic [3:0]     obs_piece [8];
  logic [1:0]     obs_rot [8];
  logic [X_W-1:0] obs_x [8];
  logic [Y_W-1:0] obs_y [8];
  int             n_chk, done_cyc, wait_cyc;
  logic           obs_ok, unstable, done_after;
  logic [1:0]     obs_new_rot;
  logic [X_W-1:0] obs_new_x;
  logic [Y_W-1:0] obs_new_y;
  logic [2:0]     obs_kick;

  tetromino_rotate_ctrl #(.X_W(X_W), .Y_W(Y_W), .KICKS(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .piece(piece), .cur_rot(cur_rot), .cur_x(cur_x), .cur_y(cur_y),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_piece(chk_piece), .chk_rot(chk_rot),
    .chk_x(chk_x), .chk_y(chk_y), .chk_resp_valid(chk_resp_valid), .chk_collide(chk_collide),
    .done(done), .done_ok(done_ok), .new_rot(new_rot), .new_x(new_x), .new_y(new_y),
    .kick_idx(kick_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  // Issues one rotate request and plays the checker: verdicts come from mask[n], the
  // first candidate is back-pressured for 'stall' cycles. Cycles count from the accept cycle.
  task automatic run_rot(input logic [3:0] p, input logic [1:0] r, input logic [X_W-1:0] x,
                         input logic [Y_W-1:0] y, input logic [DIR_W-1:0] d,
                         input logic [4:0] mask, input int stall);
    logic        pending, stalled_prev;
    logic [17:0] hold;
    int          stall_left, c;
    @(negedge clk);
    done_after = done;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
    checks++;
    piece = p; cur_rot = r; cur_x = x; cur_y = y; req_dir = d; req_valid = 1'b1;
    n_chk = 0; done_cyc = -1; pending = 1'b0; stalled_prev = 1'b0; unstable = 1'b0;
    stall_left = stall; c = 0; hold = '0;
    while (done_cyc < 0 && c < 200) begin
      @(negedge clk);
      c++;
      req_valid = 1'b0;
      chk_resp_valid = pending;
      chk_collide = pending ? ((n_chk <= 5) ? mask[n_chk-1] : 1'b1) : 1'b0;
      pending = 1'b0;
      chk_ready = 1'b0;
      if (chk_valid) begin
        if (stalled_prev && {chk_piece, chk_rot, chk_x, chk_y} !== hold) unstable = 1'b1;
        hold = {chk_piece, chk_rot, chk_x, chk_y};
        if (stall_left > 0) begin
          stall_left--;
          stalled_prev = 1'b1;
        end else begin
          chk_ready = 1'b1;
          stalled_prev = 1'b0;
          if (n_chk < 8) begin
            obs_piece[n_chk] = chk_piece; obs_rot[n_chk] = chk_rot;
            obs_x[n_chk] = chk_x; obs_y[n_chk] = chk_y;
          end
          n_chk++;
          pending = 1'b1;
        end
      end
      if (done) begin
        done_cyc = c; obs_ok = done_ok; obs_new_rot = new_rot;
        obs_new_x = new_x; obs_new_y = new_y; obs_kick = kick_idx;
      end
    end
    chk_resp_valid = 1'b0; chk_collide = 1'b0; chk_ready = 1'b0;
    $display("rotate piece=%0d rot=%0d x=%0d y=%0d dir=%0d: checks=%0d done_cyc=%0d ok=%b new=(%0d,%0d,%0d) kick=%0d",
             p, r, x, y, d, n_chk, done_cyc, obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if ({chk_valid, done, done_ok} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {chk_valid, done, done_ok}); end
    checks++;
    if ({chk_piece, chk_rot, chk_x, chk_y} !== 18'd0) begin errors++; $display("FAIL reset_chk: got %h want 0", {chk_piece, chk_rot, chk_x, chk_y}); end
    checks++;
    if ({new_rot, new_x, new_y, kick_idx} !== 17'd0) begin errors++; $display("FAIL reset_new: got %h want 0", {new_rot, new_x, new_y, kick_idx}); end
    checks++;
  endtask

  task automatic test_t_no_collide;
    run_rot(PIECE_T, 2'd0, 5'd4, 7'd20, '0, 5'b00000, 0);
    if (n_chk !== 1) begin errors++; $display("FAIL t0_count: got %0d want 1", n_chk); end
    checks++;
    if ({obs_piece[0], obs_rot[0], obs_x[0], obs_y[0]} !== {PIECE_T, 2'd1, 5'd4, 7'd20}) begin
      errors++; $display("FAIL t0_cand: got p%0d r%0d (%0d,%0d) want p7 r1 (4,20)", obs_piece[0], obs_rot[0], obs_x[0], obs_y[0]);
    end
    checks++;
    if (done_cyc !== 4) begin errors++; $display("FAIL t0_latency: got %0d want 4", done_cyc); end
    checks++;
    if ({obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick} !== {1'b1, 5'd4, 7'd20, 2'd1, 3'd0}) begin
      errors++; $display("FAIL t0_result: got ok%b (%0d,%0d,%0d) k%0d want ok1 (4,20,1) k0", obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
    end
    checks++;
  endtask

  task automatic test_t_kick2;
    int ex[3] = '{4, 3, 3};
    int ey[3] = '{20, 20, 21};
    run_rot(PIECE_T, 2'd0, 5'd4, 7'd20, '0, 5'b00011, 0);
    if (n_chk !== 3) begin errors++; $display("FAIL tk_count: got %0d want 3", n_chk); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (obs_x[i] !== X_W'(ex[i]) || obs_y[i] !== Y_W'(ey[i]) || obs_rot[i] !== 2'd1) begin
        errors++; $display("FAIL tk_cand%0d: got (%0d,%0d,%0d) want (%0d,%0d,1)", i, obs_x[i], obs_y[i], obs_rot[i], ex[i], ey[i]);
      end
      checks++;
    end
    if (done_cyc !== 10) begin errors++; $display("FAIL tk_latency: got %0d want 10", done_cyc); end
    checks++;
    if ({obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick} !== {1'b1, 5'd3, 7'd21, 2'd1, 3'd2}) begin
      errors++; $display("FAIL tk_result: got ok%b (%0d,%0d,%0d) k%0d want ok1 (3,21,1) k2", obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
    end
    checks++;
  endtask

  task automatic test_i_all_collide;
    int ex[5] = '{5, 3, 6, 3, 6};
    int ey[5] = '{20, 20, 20, 19, 22};
    run_rot(PIECE_I, 2'd0, 5'd4, 7'd20, '0, 5'b11111, 0);
    if (n_chk !== 5) begin errors++; $display("FAIL ia_count: got %0d want 5", n_chk); end
    checks++;
    for (int i = 0; i < 5; i++) begin
      if (obs_x[i] !== X_W'(ex[i]) || obs_y[i] !== Y_W'(ey[i]) || obs_rot[i] !== 2'd1) begin
        errors++; $display("FAIL ia_cand%0d: got (%0d,%0d,%0d) want (%0d,%0d,1)", i, obs_x[i], obs_y[i], obs_rot[i], ex[i], ey[i]);
      end
      checks++;
    end
    if (done_cyc !== 16) begin errors++; $display("FAIL ia_latency: got %0d want 16", done_cyc); end
    checks++;
    if ({obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick} !== {1'b0, 5'd4, 7'd20, 2'd0, 3'd4}) begin
      errors++; $display("FAIL ia_result: got ok%b (%0d,%0d,%0d) k%0d want ok0 (4,20,0) k4", obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
    end
    checks++;
  endtask

  task automatic test_o_collide;
    run_rot(PIECE_O, 2'd0, 5'd4, 7'd20, '0, 5'b11111, 0);
    if (n_chk !== 1) begin errors++; $display("FAIL o_count: got %0d want 1", n_chk); end
    checks++;
    if ({obs_x[0], obs_y[0], obs_rot[0]} !== {5'd4, 7'd21, 2'd1}) begin
      errors++; $display("FAIL o_cand: got (%0d,%0d,%0d) want (4,21,1)", obs_x[0], obs_y[0], obs_rot[0]);
    end
    checks++;
    if ({obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick} !== {1'b0, 5'd4, 7'd20, 2'd0, 3'd0}) begin
      errors++; $display("FAIL o_result: got ok%b (%0d,%0d,%0d) k%0d want ok0 (4,20,0) k0", obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
    end
    checks++;
  endtask

  task automatic test_t_ccw;
    run_rot(PIECE_T, 2'd0, 5'd4, 7'd20, DIR_W'(1), 5'b00001, 0);
    if (n_chk !== 2 || {obs_x[1], obs_y[1], obs_rot[1]} !== {5'd5, 7'd20, 2'd3}) begin
      errors++; $display("FAIL ccw_cand: got n%0d (%0d,%0d,%0d) want n2 (5,20,3)", n_chk, obs_x[1], obs_y[1], obs_rot[1]);
    end
    checks++;
    if ({obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick} !== {1'b1, 5'd5, 7'd20, 2'd3, 3'd1}) begin
      errors++; $display("FAIL ccw_result: got ok%b (%0d,%0d,%0d) k%0d want ok1 (5,20,3) k1", obs_ok, obs_new_x, obs_new_y, obs_new_rot, obs_kick);
    end
    checks++;
  endtask

  task automatic test_x_wrap;
    run_rot(PIECE_I, 2'd0, 5'd15, 7'd20, '0, 5'b00000, 0);
    if ({obs_x[0], obs_y[0], obs_rot[0]} !== {5'b10000, 7'd20, 2'd1}) begin
      errors++; $display("FAIL wrap_cand: got (%b,%0d,%0d) want (10000,20,1)", obs_x[0], obs_y[0], obs_rot[0]);
    end
    checks++;
    if ({obs_ok, obs_new_x} !== {1'b1, 5'b10000}) begin
      errors++; $display("FAIL wrap_result: got ok%b x=%b want ok1 x=10000", obs_ok, obs_new_x);
    end
    checks++;
  endtask

  task automatic test_backpressure;
    run_rot(PIECE_T, 2'd0, 5'd4, 7'd20, '0, 5'b00000, 3);
    if (unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got changed=%b want 0", unstable); end
    checks++;
    if (done_cyc !== 7) begin errors++; $display("FAIL bp_latency: got %0d want 7", done_cyc); end
    checks++;
    if ({n_chk == 1, obs_ok, obs_new_x, obs_new_y, obs_new_rot} !== {1'b1, 1'b1, 5'd4, 7'd20, 2'd1}) begin
      errors++; $display("FAIL bp_result: got n%0d ok%b (%0d,%0d,%0d) want n1 ok1 (4,20,1)", n_chk, obs_ok, obs_new_x, obs_new_y, obs_new_rot);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    run_rot(PIECE_T, 2'd0, 5'd4, 7'd20, '0, 5'b00000, 0);
    run_rot(PIECE_T, 2'd1, 5'd4, 7'd20, '0, 5'b00000, 0);
    if (done_after !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b want 0", done_after); end
    checks++;
    if (wait_cyc !== 0) begin errors++; $display("FAIL b2b_ready: got %0d wait cycles want 0", wait_cyc); end
    checks++;
    if ({done_cyc == 4, obs_ok, obs_new_x, obs_new_y, obs_new_rot} !== {1'b1, 1'b1, 5'd4, 7'd20, 2'd2}) begin
      errors++; $display("FAIL b2b_result: got cyc%0d ok%b (%0d,%0d,%0d) want cyc4 ok1 (4,20,2)", done_cyc, obs_ok, obs_new_x, obs_new_y, obs_new_rot);
    end
    checks++;
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    piece = PIECE_T; cur_rot = 2'd0; cur_x = 5'd6; cur_y = 7'd9; req_dir = '0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    if (chk_valid !== 1'b1) begin errors++; $display("FAIL rw_issue: got chk_valid=%b want 1", chk_valid); end
    checks++;
    chk_ready = 1'b1;
    @(negedge clk);
    chk_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if ({req_ready, chk_valid, done, done_ok} !== 4'b1000) begin
      errors++; $display("FAIL rw_flags: got %b want 1000", {req_ready, chk_valid, done, done_ok});
    end
    checks++;
    if ({chk_piece, chk_rot, chk_x, chk_y, new_rot, new_x, new_y, kick_idx} !== 35'd0) begin
      errors++; $display("FAIL rw_regs: got %h want 0", {chk_piece, chk_rot, chk_x, chk_y, new_rot, new_x, new_y, kick_idx});
    end
    checks++;
    chk_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) begin errors++; $display("FAIL rw_late_resp%0d: got done=%b want 0", i, done); end
      checks++;
    end
    chk_resp_valid = 1'b0;
    $display("reset in WAIT: late verdict ignored");
  endtask

  initial begin
    test_reset();
    test_t_no_collide();
    test_t_kick2();
    test_i_all_collide();
    test_o_collide();
    test_t_ccw();
    test_x_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetromino_rotate_ctrl.md
# tetromino_rotate_ctrl

Sequential rotation controller for the active piece. It accepts a rotate request, steps through the SRS kick candidates (index 0..4), and asks the external collision checker about each candidate over a valid/ready handshake. It commits the first candidate that does not collide, or reports failure after the last one. It sits between the input/gravity control FSM (upstream) and the board collision checker, and it consumes the per-rotation offset data produced by the `tetromino_rotate_datum` offset table.

## Interface
- `X_W`, 5: signed width of the piece-origin column.
- `Y_W`, 7: signed width of the piece-origin row (row index increases upward).
- `KICKS`, 5: number of kick candidates for non-O pieces.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: rotate request.
- `req_ready` out 1: high only in IDLE.
- `req_dir` in 1 (2 with `TETRIS_ROTATE_180_EN`): 0=CW, 1=CCW, 2=180.
- `piece` in 4: piece code (L=1, J=2, I=3, O=4, Z=5, S=6, T=7).
- `cur_rot` in 2: current rotation (0, R=1, 2, L=3).
- `cur_x` in X_W, `cur_y` in Y_W: current origin, signed.
- `chk_valid` out 1, `chk_ready` in 1: candidate handshake.
- `chk_piece` out 4, `chk_rot` out 2, `chk_x` out X_W, `chk_y` out Y_W: candidate.
- `chk_resp_valid` in 1, `chk_collide` in 1: checker verdict.
- `done` out 1: one-cycle completion pulse.
- `done_ok` out 1: rotation succeeded (valid with `done`).
- `new_rot` out 2, `new_x` out X_W, `new_y` out Y_W, `kick_idx` out 3: result (valid with `done`).

## Operation
- **Accept.** The request is accepted on `req_valid && req_ready`. At acceptance the block latches `piece`, `cur_rot`, `cur_x`, `cur_y`, `req_dir` and sets the index to 0.
- **Target rotation.** `to_rot = cur_rot + 1` for CW, `cur_rot - 1` for CCW, `cur_rot + 2` for 180, all mod 4.
- **Kick.** `kick = offset(piece, from_rot, idx) - offset(piece, to_rot, idx)`, taken from two offset-table lookups.
- **Candidate.** `chk_x = cur_x + kick_x` and `chk_y = cur_y + kick_y`. Sign-extend the addends to X_W/Y_W and let the result wrap; bounds are the checker's job. `chk_rot = to_rot`.
- **Index range.** O piece: index 0 only. 180 rotation: index 0 only. All other pieces: indices 0..KICKS-1.
- **FSM:**
  - IDLE → CALC on accept.
  - CALC: register the candidate → ISSUE.
  - ISSUE: `chk_valid` = 1 → WAIT on `chk_ready`.
  - WAIT, on `chk_resp_valid`:
    - `chk_collide` = 0 → DONE with success.
    - `chk_collide` = 1 and more indices remain → idx++, go to CALC.
    - `chk_collide` = 1 on the last index → DONE with failure.
  - DONE: `done` = 1 for one cycle → IDLE.
- **Results.**
  - Success: `new_*` = candidate, `kick_idx` = idx, `done_ok` = 1.
  - Failure: `new_*` = latched current state, `kick_idx` = last index tried, `done_ok` = 0.
- **Ignored inputs.** `chk_resp_valid` outside WAIT is ignored. `req_valid` while busy is ignored; no queueing.

## Timing
- **Reset values.** All registered outputs are 0 (`chk_valid`, `done`, `done_ok`, `chk_*`, `new_*`, `kick_idx`). State is IDLE, so `req_ready` = 1 in the first cycle after `reset` falls.
- **Reset mid-operation.** Reset returns the block to IDLE the next edge and drops `chk_valid` even mid-handshake. A verdict arriving later is ignored.
- **Candidate stability.** `chk_*` are held stable while `chk_valid` = 1 and `chk_ready` = 0.
- **Earliest checker response.** The checker may assert `chk_resp_valid` no earlier than the cycle after the `chk_valid && chk_ready` handshake.
- **Latency.** With accept in cycle 0, a zero-wait checker gives:
  - CALC in cycle 1, ISSUE in 2, response in 3, `done` in 4.
  - Each further kick adds 3 cycles; each `chk_ready`-low or response-wait cycle adds 1.
- **Back-to-back requests.** A new request can be accepted the cycle after `done`.

## Configuration
- **`TETRIS_ROTATE_180_EN` defined:** `req_dir` is 2 bits and value 2 is a 180 rotation, index 0 only. Value 3 is treated as CW.
- **Undefined:** `req_dir` is 1 bit and there is no 180 path.

## Structure
- **Shared package `tetris_pkg`:** piece codes, rotation codes, the FSM state encoding, and the `KICKS` default.
- **Sub-modules:** two `tetromino_rotate_datum` instances (from-rotation and to-rotation, sharing piece and idx). No new sub-module; the subtract/add datapath is inline.

## Test plan
- **T, no collisions:** T at (4,20) rot 0, CW, checker never collides → exactly one check at (4,20, rot 1). Expect `done` in cycle 4, `done_ok` = 1, `new` = (4,20,1), `kick_idx` = 0.
- **T, kick to idx 2:** T at (4,20) rot 0, CW, collide on idx 0 and 1 → checks at (4,20), (3,20), (3,21). Expect `done_ok` = 1, `new` = (3,21,1), `kick_idx` = 2.
- **I, all collide:** I at (4,20) rot 0, CW, all collide → 5 checks at (5,20), (3,20), (6,20), (3,19), (6,22). Expect `done_ok` = 0, `new` = (4,20,0), `kick_idx` = 4.
- **O, collides:** O at (4,20) rot 0, CW, collide → a single check at (4,21, rot 1), then `done_ok` = 0.
- **Backpressure:** hold `chk_ready` low for 3 cycles in the first scenario → `chk_*` stay stable and `done` arrives in cycle 7.
- **Reset in WAIT:** assert `reset` while in WAIT → next cycle all outputs are 0 and `req_ready` = 1. A subsequent `chk_resp_valid` produces no `done`.
